i2c_master_arbiter: RTL and testbench
=====================================

Name: i2c_master_arbiter

Overview:
Shares one I2C_MASTER instance between NREQ on-chip requesters.
- Round-robin selects one pending request and latches its transaction parameters.
- Drives the master's Start/RorW/Slave_Address/NBytes and streams its DataToSlave.
- Monitors the master's State output to detect launch and completion, then returns read data and a per-requester Done pulse.

Parameters:
NREQ, 4, number of requesters (2..8)
ADDRESSLENGTH, 7, slave address width; must match the attached I2C_MASTER
TIMEOUT_CYCLES, 4096, Clk cycles allowed for one transaction (used only with the optional feature)

Ports:
Clk  input  1  system clock; the same clock drives I2C_MASTER Clk
Rst  input  1  synchronous, active-low reset
Req  input  NREQ  per-requester transaction request, level
Req_RorW  input  NREQ  per-requester direction: 1 = write to slave, 0 = read
Req_Address  input  NREQ*ADDRESSLENGTH  flattened slave addresses; requester i uses slice i
Req_NBytes  input  NREQ*4  flattened byte counts
Req_Data  input  NREQ*8  flattened write data; the granted slice is passed through live
Gnt  output  NREQ  one-hot grant, held for the whole transaction
Done  output  NREQ  one-hot, one-cycle completion pulse
Rd_Data  output  8  M_DataFromSlave captured at completion
Err  output  NREQ  one-cycle timeout/launch-failure pulse, aligned with Done
M_Start  output  1  to master Start
M_RorW  output  1  to master RorW
M_Slave_Address  output  ADDRESSLENGTH  to master Slave_Address
M_NBytes  output  4  to master NBytes
M_DataToSlave  output  8  to master DataToSlave
M_State  input  4  from master State; 0 = IDLE
M_DataFromSlave  input  8  from master DataFromSlave

Behaviour:
- Reset (Rst=0 at a Clk edge):
  - state IDLE; round-robin pointer 0.
  - Gnt, Done, Err, M_Start, M_RorW, M_Slave_Address, M_NBytes and Rd_Data all 0.
  - A transaction in progress is abandoned. The master is reset by its own Rst.
- State machine: IDLE, LAUNCH, BUSY, DONE.
- IDLE:
  - If any Req bit is set and M_State==0, pick the winner: the first set bit at or above the pointer, wrapping modulo NREQ.
  - Latch the winner's RorW, Address and NBytes into the M_* registers.
  - Set Gnt[winner], M_Start=1, pointer=(winner+1) mod NREQ, next state LAUNCH.
  - Latency: Req sampled at edge n gives Gnt and M_Start visible after edge n.
- LAUNCH: hold M_Start=1 until M_State!=0, then M_Start=0 and go to BUSY.
- BUSY: when M_State==0, capture Rd_Data from M_DataFromSlave and go to DONE.
- DONE (one cycle):
  - Done[winner]=1; Gnt cleared at the next edge; return to IDLE.
  - The earliest next grant is the cycle after DONE, so there is one idle cycle between transactions.
- Data path:
  - M_DataToSlave = Req_Data slice of the granted requester, combinational.
  - 0 when nothing is granted.
- Boundary conditions:
  - Req dropped while granted: ignored; the transaction completes and Done is still pulsed.
  - Req held through DONE: the requester is re-arbitrated with lowest priority after the pointer advance. There is no back-to-back starvation.
  - All NREQ requesting: grants go strictly i, i+1, … in rotation.
  - Req_NBytes==0: passed through unchanged; the master terminates after the address ACK.
  - Latched parameters do not change during a transaction, even if the requester's inputs change.

Optional Feature:
Macro I2C_ARB_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES)+1 clears on entry to LAUNCH and increments in LAUNCH and BUSY.
  - Reaching TIMEOUT_CYCLES forces DONE with Err[winner]=1 and Done[winner]=1, M_Start=0, Rd_Data unchanged.
- Undefined: no counter; Err is tied to 0; LAUNCH/BUSY wait indefinitely.

Decomposition:
- Package i2c_arb_pkg:
  - arbiter state encoding.
  - MASTER_IDLE=4'd0, matching the master's state code.
  - NBYTES_W=4.
- Sub-module i2c_rr_pick:
  - combinational round-robin priority picker.
  - inputs: request vector and pointer.
  - outputs: one-hot winner, winner index, any-valid.

Test Plan:
- Single request: Req=4'b0010, addr 7'h50, RorW=1, NBytes=2, with the master model → Gnt=0010 after 1 cycle; M_Slave_Address=7'h50, M_Start high until M_State!=0; Done=0010 for one cycle when M_State returns to 0.
- Contention: Req=4'b1111 held → grant order 0001, 0010, 0100, 1000, 0001, with one idle cycle between Done and the next Gnt.
- Read: requester 2, RorW=0, NBytes=1, slave returns 8'hA5 → Rd_Data=8'hA5 in the Done cycle; Done=0100.
- Parameter stability: change Req_Address[0] to 7'h11 mid-transaction → M_Slave_Address stays 7'h50 until DONE.
- Reset mid-BUSY: Rst=0 for one edge → all outputs 0 next cycle, pointer 0; a following Req=1001 grants 0001.
- (I2C_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=64) M_State stuck at 0 after M_Start → Err and Done pulse on requester 0 after 64 cycles, M_Start=0.

Source files
------------

// File: rtl/i2c_arb_pkg.sv
// rtl/i2c_arb_pkg.sv - shared types and constants for the I2C master arbiter
package i2c_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_LAUNCH = 2'd1,
    ARB_BUSY   = 2'd2,
    ARB_DONE   = 2'd3
  } arb_state_t;

  localparam logic [3:0] MASTER_IDLE = 4'd0;
  localparam int         NBYTES_W    = 4;

endpackage

// File: rtl/i2c_rr_pick.sv
// rtl/i2c_rr_pick.sv - combinational round-robin picker, first request at or above ptr
module i2c_rr_pick #(
  parameter int NREQ  = 4,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  win_onehot,
  output logic [PTR_W-1:0] win_idx,
  output logic             any_valid
);

  logic [PTR_W-1:0] cand;

  // Scan from the farthest candidate back to ptr so the nearest set bit wins last.
  always_comb begin
    win_idx    = '0;
    win_onehot = '0;
    cand       = '0;
    any_valid  = |req;
    for (int k = NREQ - 1; k >= 0; k--) begin
      cand = PTR_W'((int'(ptr) + k) % NREQ);
      if (req[cand]) win_idx = cand;
    end
    if (any_valid) win_onehot[win_idx] = 1'b1;
  end

endmodule

// File: rtl/i2c_master_arbiter.sv
// rtl/i2c_master_arbiter.sv - shares one I2C_MASTER among NREQ requesters; optional I2C_ARB_TIMEOUT_EN
module i2c_master_arbiter
  import i2c_arb_pkg::*;
#(
  parameter int NREQ           = 4,
  parameter int ADDRESSLENGTH  = 7,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [NREQ-1:0]               Req,
  input  logic [NREQ-1:0]               Req_RorW,
  input  logic [NREQ*ADDRESSLENGTH-1:0] Req_Address,
  input  logic [NREQ*NBYTES_W-1:0]      Req_NBytes,
  input  logic [NREQ*8-1:0]             Req_Data,
  output logic [NREQ-1:0]               Gnt,
  output logic [NREQ-1:0]               Done,
  output logic [7:0]                    Rd_Data,
  output logic [NREQ-1:0]               Err,
  output logic                          M_Start,
  output logic                          M_RorW,
  output logic [ADDRESSLENGTH-1:0]      M_Slave_Address,
  output logic [NBYTES_W-1:0]           M_NBytes,
  output logic [7:0]                    M_DataToSlave,
  input  logic [3:0]                    M_State,
  input  logic [7:0]                    M_DataFromSlave
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_t               state_q, state_d;
  logic [PTR_W-1:0]         ptr_q, ptr_d;
  logic [NREQ-1:0]          gnt_q, gnt_d;
  logic [NREQ-1:0]          done_q, done_d;
  logic                     start_q, start_d;
  logic                     rorw_q, rorw_d;
  logic [ADDRESSLENGTH-1:0] addr_q, addr_d;
  logic [NBYTES_W-1:0]      nb_q, nb_d;
  logic [7:0]               rd_q, rd_d;

  logic [NREQ-1:0]          pick_onehot;
  logic [PTR_W-1:0]         pick_idx;
  logic                     pick_valid;

  i2c_rr_pick #(
    .NREQ  (NREQ),
    .PTR_W (PTR_W)
  ) u_pick (
    .req        (Req),
    .ptr        (ptr_q),
    .win_onehot (pick_onehot),
    .win_idx    (pick_idx),
    .any_valid  (pick_valid)
  );

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0]  err_q, err_d;
`endif

  // State and transaction registers; reset abandons any transaction in flight.
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state_q <= ARB_IDLE;
      ptr_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      start_q <= 1'b0;
      rorw_q  <= 1'b0;
      addr_q  <= '0;
      nb_q    <= '0;
      rd_q    <= '0;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      start_q <= start_d;
      rorw_q  <= rorw_d;
      addr_q  <= addr_d;
      nb_q    <= nb_d;
      rd_q    <= rd_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: grant and latch in IDLE, drop Start once the master leaves idle,
  // capture read data when the master returns to idle, pulse Done for one cycle.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    start_d = start_q;
    rorw_d  = rorw_q;
    addr_d  = addr_q;
    nb_d    = nb_q;
    rd_d    = rd_q;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = '0;
`endif
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid && (M_State == MASTER_IDLE)) begin
          for (int i = 0; i < NREQ; i++) begin
            if (pick_onehot[i]) begin
              rorw_d = Req_RorW[i];
              addr_d = Req_Address[i*ADDRESSLENGTH +: ADDRESSLENGTH];
              nb_d   = Req_NBytes[i*NBYTES_W +: NBYTES_W];
            end
          end
          gnt_d   = pick_onehot;
          start_d = 1'b1;
          ptr_d   = PTR_W'((int'(pick_idx) + 1) % NREQ);
          state_d = ARB_LAUNCH;
`ifdef I2C_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ARB_LAUNCH: begin
        if (M_State != MASTER_IDLE) begin
          start_d = 1'b0;
          state_d = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (M_State == MASTER_IDLE) begin
          rd_d    = M_DataFromSlave;
          done_d  = gnt_q;
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: begin
        gnt_d   = '0;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
`ifdef I2C_ARB_TIMEOUT_EN
    // A stuck master ends the transaction with Err; timeout wins over a same-cycle completion.
    if ((state_q == ARB_LAUNCH) || (state_q == ARB_BUSY)) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        start_d = 1'b0;
        rd_d    = rd_q;
        done_d  = gnt_q;
        err_d   = gnt_q;
        state_d = ARB_DONE;
      end
    end
`endif
  end

  // Live write-data mux from the granted requester; zero when nobody holds the grant.
  always_comb begin
    M_DataToSlave = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) M_DataToSlave = Req_Data[i*8 +: 8];
    end
  end

  assign Gnt             = gnt_q;
  assign Done            = done_q;
  assign Rd_Data         = rd_q;
  assign M_Start         = start_q;
  assign M_RorW          = rorw_q;
  assign M_Slave_Address = addr_q;
  assign M_NBytes        = nb_q;
`ifdef I2C_ARB_TIMEOUT_EN
  assign Err             = err_q;
`else
  assign Err             = '0;
`endif

endmodule

// File: tb/tb_i2c_master_arbiter.sv
// tb/tb_i2c_master_arbiter.sv - self-checking bench with master model and transaction-level reference
module tb_i2c_master_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 7;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int TMO  = 64;
`else
  localparam int TMO  = 4096;
`endif

  logic                 Clk;
  logic                 Rst;
  logic [NREQ-1:0]      Req;
  logic [NREQ-1:0]      Req_RorW;
  logic [NREQ*AW-1:0]   Req_Address;
  logic [NREQ*4-1:0]    Req_NBytes;
  logic [NREQ*8-1:0]    Req_Data;
  logic [NREQ-1:0]      Gnt;
  logic [NREQ-1:0]      Done;
  logic [7:0]           Rd_Data;
  logic [NREQ-1:0]      Err;
  logic                 M_Start;
  logic                 M_RorW;
  logic [AW-1:0]        M_Slave_Address;
  logic [3:0]           M_NBytes;
  logic [7:0]           M_DataToSlave;
  logic [3:0]           M_State;
  logic [7:0]           M_DataFromSlave;

  i2c_master_arbiter #(
    .NREQ           (NREQ),
    .ADDRESSLENGTH  (AW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .Clk             (Clk),
    .Rst             (Rst),
    .Req             (Req),
    .Req_RorW        (Req_RorW),
    .Req_Address     (Req_Address),
    .Req_NBytes      (Req_NBytes),
    .Req_Data        (Req_Data),
    .Gnt             (Gnt),
    .Done            (Done),
    .Rd_Data         (Rd_Data),
    .Err             (Err),
    .M_Start         (M_Start),
    .M_RorW          (M_RorW),
    .M_Slave_Address (M_Slave_Address),
    .M_NBytes        (M_NBytes),
    .M_DataToSlave   (M_DataToSlave),
    .M_State         (M_State),
    .M_DataFromSlave (M_DataFromSlave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired at %0t", nm, $time);
  endtask

  // I2C master stand-in: accepts Start when idle, goes busy after a latency, returns to idle.
  int         lat_lo = 1, lat_hi = 1, blen_lo = 6, blen_hi = 6;
  bit         mst_stuck = 0;
  logic [7:0] mst_data = 8'h00;
  int         mph = 0, mlat = 0, mblen = 0;

  always @(posedge Clk) begin
    if (!Rst) begin
      mph = 0;
      M_State         <= 4'd0;
      M_DataFromSlave <= 8'd0;
    end else begin
      case (mph)
        0: if (M_Start && !mst_stuck) begin
          mlat  = $urandom_range(lat_hi, lat_lo);
          mblen = $urandom_range(blen_hi, blen_lo);
          if (mlat == 0) begin
            M_State <= 4'd3;
            mph = 2;
          end else mph = 1;
        end
        1: begin
          mlat--;
          if (mlat == 0) begin
            M_State <= 4'd3;
            mph = 2;
          end
        end
        default: begin
          mblen--;
          if (mblen == 0) begin
            M_State         <= 4'd0;
            M_DataFromSlave <= mst_data;
            mph = 0;
          end
        end
      endcase
    end
  end

  // Reference: one transaction at a time, owner index plus launch/finish flags.
  int         m_own = -1, m_ptr = 0, m_tmo = 0;
  bit         m_stp = 0, m_fin = 0, m_err = 0;
  bit         m_rorw = 0;
  logic [6:0] m_addr = '0;
  logic [3:0] m_nb = '0;
  logic [7:0] m_rd = '0;

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  task automatic model_step();
    bit timed_out;
    timed_out = 0;
    if (!Rst) begin
      m_own = -1; m_ptr = 0; m_tmo = 0;
      m_stp = 0; m_fin = 0; m_err = 0;
      m_rorw = 0; m_addr = '0; m_nb = '0; m_rd = '0;
    end else if (m_fin) begin
      m_fin = 0; m_err = 0; m_own = -1;
    end else if (m_own < 0) begin
      if (Req != 0 && M_State == 4'd0) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (m_ptr + k) % NREQ;
          if (m_own < 0 && Req[j]) m_own = j;
        end
        m_rorw = Req_RorW[m_own];
        m_addr = Req_Address[m_own*AW +: AW];
        m_nb   = Req_NBytes[m_own*4 +: 4];
        m_stp  = 1;
        m_ptr  = (m_own + 1) % NREQ;
        m_tmo  = 0;
      end
    end else begin
`ifdef I2C_ARB_TIMEOUT_EN
      m_tmo++;
      if (m_tmo >= TMO) timed_out = 1;
`endif
      if (timed_out) begin
        m_fin = 1; m_err = 1; m_stp = 0;
      end else if (m_stp) begin
        if (M_State != 4'd0) m_stp = 0;
      end else if (M_State == 4'd0) begin
        m_rd  = M_DataFromSlave;
        m_fin = 1;
      end
    end
  endtask

  // Every-cycle comparison against the reference, 1 time unit after the edge.
  always @(posedge Clk) begin
    logic [7:0] e_dts;
    model_step();
    #1;
    e_dts = (m_own >= 0) ? Req_Data[m_own*8 +: 8] : 8'd0;
    chk("gnt",      Gnt,             oh(m_own));
    chk("done",     Done,            m_fin ? oh(m_own) : '0);
    chk("err",      Err,             (m_fin && m_err) ? oh(m_own) : '0);
    chk("m_start",  M_Start,         m_stp);
    chk("m_rorw",   M_RorW,          m_rorw);
    chk("m_addr",   M_Slave_Address, m_addr);
    chk("m_nbytes", M_NBytes,        m_nb);
    chk("m_dts",    M_DataToSlave,   e_dts);
    chk("rd_data",  Rd_Data,         m_rd);
  end

  task automatic sample();
    @(posedge Clk);
    #2;
  endtask

  task automatic wait_done(input string nm, input int maxc, output logic [NREQ-1:0] d);
    d = '0;
    for (int i = 0; i < maxc; i++) begin
      sample();
      if (Done != 0) begin
        d = Done;
        break;
      end
    end
    if (d == 0) fail_now(nm);
  endtask

  logic [NREQ-1:0] cexp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    logic [NREQ-1:0] d;
    int cyc;
    Rst = 1'b0; Req = '0; Req_RorW = '0; Req_Address = '0; Req_NBytes = '0; Req_Data = '0;
    repeat (2) sample();
    chk("rst_gnt", Gnt, 0);
    chk("rst_start", M_Start, 0);
    chk("rst_addr", M_Slave_Address, 0);
    chk("rst_rd", Rd_Data, 0);
    @(negedge Clk);
    Rst = 1'b1;

    // single write request from requester 1, dropped after grant
    @(negedge Clk);
    Req = 4'b0010; Req_RorW = 4'b0010;
    Req_Address[1*AW +: AW] = 7'h50; Req_NBytes[4 +: 4] = 4'd2; Req_Data[8 +: 8] = 8'h3C;
    sample();
    chk("single_gnt", Gnt, 4'b0010);
    chk("single_start", M_Start, 1);
    chk("single_addr", M_Slave_Address, 7'h50);
    chk("single_nb", M_NBytes, 2);
    chk("single_dts", M_DataToSlave, 8'h3C);
    @(negedge Clk);
    Req = '0;
    wait_done("single_wait", 50, d);
    chk("single_done", d, 4'b0010);
    sample();
    chk("single_gnt_clr", Gnt, 0);

    // read from requester 2
    @(negedge Clk);
    mst_data = 8'hA5; Req = 4'b0100; Req_RorW = 4'b0000;
    Req_Address[2*AW +: AW] = 7'h2A; Req_NBytes[8 +: 4] = 4'd1;
    sample();
    chk("read_gnt", Gnt, 4'b0100);
    @(negedge Clk);
    Req = '0;
    wait_done("read_wait", 50, d);
    chk("read_done", d, 4'b0100);
    chk("read_data", Rd_Data, 8'hA5);
    sample();

    // latched parameters survive input changes
    @(negedge Clk);
    Req = 4'b0001; Req_RorW = 4'b0001; Req_Address[0 +: AW] = 7'h50; Req_NBytes[0 +: 4] = 4'd3;
    sample();
    chk("stab_gnt", Gnt, 4'b0001);
    @(negedge Clk);
    Req = '0; Req_RorW = '0; Req_Address[0 +: AW] = 7'h11; Req_NBytes[0 +: 4] = 4'd7;
    wait_done("stab_wait", 50, d);
    chk("stab_addr", M_Slave_Address, 7'h50);
    chk("stab_nb", M_NBytes, 3);
    chk("stab_rorw", M_RorW, 1);
    sample();

    // full contention after reset: strict rotation with one idle cycle between
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1; Req = 4'b1111;
    sample();
    chk("cont_gnt0", Gnt, cexp[0]);
    for (int k = 1; k < 5; k++) begin
      wait_done("cont_wait", 50, d);
      chk("cont_done", d, cexp[k-1]);
      sample();
      chk("cont_gap", Gnt, 0);
      sample();
      chk("cont_gnt", Gnt, cexp[k]);
    end
    @(negedge Clk);
    Req = '0;
    wait_done("cont_last", 50, d);
    sample();

    // reset while the master is busy
    @(negedge Clk);
    Req = 4'b0100;
    sample();
    chk("rb_gnt", Gnt, 4'b0100);
    @(negedge Clk);
    Req = '0;
    cyc = 0;
    while (M_Start && cyc < 20) begin
      sample();
      cyc++;
    end
    if (M_Start) fail_now("rb_busy_wait");
    @(negedge Clk);
    Rst = 1'b0;
    sample();
    chk("rb_gnt0", Gnt, 0);
    chk("rb_start0", M_Start, 0);
    chk("rb_addr0", M_Slave_Address, 0);
    @(negedge Clk);
    Rst = 1'b1; Req = 4'b1001;
    sample();
    chk("rb_regnt", Gnt, 4'b0001);
    @(negedge Clk);
    Req = '0;
    wait_done("rb_wait", 50, d);
    sample();

`ifdef I2C_ARB_TIMEOUT_EN
    // master never leaves idle: timeout after TMO cycles
    @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    Rst = 1'b1; mst_stuck = 1; Req = 4'b0001;
    sample();
    chk("tmo_gnt", Gnt, 4'b0001);
    @(negedge Clk);
    Req = '0;
    cyc = 0;
    while (Done == 0 && cyc < 200) begin
      sample();
      cyc++;
    end
    if (Done == 0) fail_now("tmo_wait");
    chk("tmo_cycles", cyc, 64);
    chk("tmo_err", Err, 4'b0001);
    chk("tmo_done", Done, 4'b0001);
    chk("tmo_start", M_Start, 0);
    mst_stuck = 0;
    sample();
`endif

    // randomized traffic checked by the reference every cycle
    lat_lo = 0; lat_hi = 3; blen_lo = 1; blen_hi = 6;
    for (int c = 0; c < 3000; c++) begin
      @(negedge Clk);
      Rst = ($urandom_range(299, 0) != 0);
      if ($urandom_range(3, 0) == 0) Req = 4'($urandom);
      Req_RorW    = 4'($urandom);
      Req_Address = 28'($urandom);
      Req_NBytes  = 16'($urandom);
      Req_Data    = 32'($urandom);
      mst_data    = 8'($urandom);
    end
    @(negedge Clk);
    Rst = 1'b1; Req = '0;
    repeat (40) sample();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
